// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick used by the two-requester scheduler.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2,
        TURN = 2'd3
    } arbstate_t;

    // On a tie the requester that did not own last wins.
    function automatic arbstate_t rr_pick(
        input logic [1:0] req,
        input logic       last
    );
        arbstate_t s;
        case (req)
            2'b01:   s = G0;
            2'b10:   s = G1;
            2'b11:   s = last ? G0 : G1;
            default: s = IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Grant tenure counter: clears outside a grant, saturates at MAXHOLD-1.
module hold_counter #(
    parameter int MAXHOLD = 4,
    parameter int CW      = $clog2(MAXHOLD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          at_limit
);

    localparam logic [CW-1:0] LIMIT = CW'(MAXHOLD - 1);

    assign at_limit = (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (!at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/arb2_sched.sv
// Two-requester round-robin scheduler with tenure limit and a
// one-cycle turnaround gap between owners.
module arb2_sched
    import arb_pkg::*;
#(
    parameter int MAXHOLD = 4,
    parameter int CW      = $clog2(MAXHOLD)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       owner,
    output logic       busy,
    output logic       preempt
);

    arbstate_t state;
    arbstate_t nxt;
    logic      last;
    logic      pre_q;
    logic      forced;
    logic      in_grant;
    logic      at_limit;
    logic [CW-1:0] hold_cnt;

    assign in_grant = (state == G0) || (state == G1);

    // Counter sits at zero outside a grant, so each tenure starts from 0.
    hold_counter #(
        .MAXHOLD (MAXHOLD),
        .CW      (CW)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (!in_grant),
        .cnt      (hold_cnt),
        .at_limit (at_limit)
    );

    always_comb begin
        nxt    = IDLE;
        forced = 1'b0;
        unique case (state)
            IDLE: nxt = rr_pick(req, last);
            G0: begin
                if (!req[0]) begin
                    nxt = TURN;
                end else if (at_limit && req[1]) begin
                    nxt    = TURN;
                    forced = 1'b1;
                end else begin
                    nxt = G0;
                end
            end
            G1: begin
                if (!req[1]) begin
                    nxt = TURN;
                end else if (at_limit && req[0]) begin
                    nxt    = TURN;
                    forced = 1'b1;
                end else begin
                    nxt = G1;
                end
            end
            TURN: nxt = rr_pick(req, last);
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b1;
            owner <= 1'b0;
            pre_q <= 1'b0;
        end else begin
            state <= nxt;
            pre_q <= forced;
            if (nxt == G0 && state != G0) begin
                owner <= 1'b0;
                last  <= 1'b0;
            end else if (nxt == G1 && state != G1) begin
                owner <= 1'b1;
                last  <= 1'b1;
            end
        end
    end

    always_comb begin
        gnt = 2'b00;
        unique case (state)
            G0:      gnt = 2'b01;
            G1:      gnt = 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign busy    = (state != IDLE);
    assign preempt = (state == TURN) && pre_q;

endmodule

// File: tb/tb_arb2_sched.sv
// Scoreboard bench for arb2_sched: a behavioural model predicts outputs
// at each drive, and they are compared after the following edge.
module tb_arb2_sched;

    localparam int MAXHOLD = 4;

    typedef struct packed {
        logic [1:0] gnt;
        logic       busy;
        logic       preempt;
        logic       owner;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt;
    logic       owner;
    logic       busy;
    logic       preempt;

    int errors = 0;
    int checks = 0;

    exp_t sbq[$];

    // Model state: 0 idle, 1 owner0, 2 owner1, 3 gap
    int   m_st = 0;
    int   m_ten = 0;
    logic m_last = 1'b1;
    logic m_owner = 1'b0;
    logic m_pre = 1'b0;

    arb2_sched #(.MAXHOLD(MAXHOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_grant(input int who);
        m_st    = who + 1;
        m_ten   = 1;
        m_owner = who[0];
        m_last  = who[0];
        m_pre   = 1'b0;
    endtask

    task automatic model_pick(input logic [1:0] r);
        if (r == 2'b01) model_grant(0);
        else if (r == 2'b10) model_grant(1);
        else if (r == 2'b11) model_grant(m_last ? 0 : 1);
        else begin
            m_st  = 0;
            m_pre = 1'b0;
        end
    endtask

    task automatic model_edge(input logic rst, input logic [1:0] r);
        int me;
        if (!rst) begin
            m_st = 0; m_ten = 0; m_last = 1'b1;
            m_owner = 1'b0; m_pre = 1'b0;
        end else if (m_st == 0 || m_st == 3) begin
            model_pick(r);
        end else begin
            me = m_st - 1;
            if (!r[me]) begin
                m_st = 3; m_pre = 1'b0;
            end else if (m_ten >= MAXHOLD && r[1-me]) begin
                m_st = 3; m_pre = 1'b1;
            end else if (m_ten < MAXHOLD) begin
                m_ten++;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.gnt     = (m_st == 1) ? 2'b01 : (m_st == 2) ? 2'b10 : 2'b00;
        e.busy    = (m_st != 0);
        e.preempt = (m_st == 3) && m_pre;
        e.owner   = m_owner;
        return e;
    endfunction

    task automatic step(input logic rst, input logic [1:0] r);
        exp_t e;
        @(negedge clk);
        reset = rst;
        req   = r;
        model_edge(rst, r);
        sbq.push_back(model_out());
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("preempt", 32'(preempt), 32'(e.preempt));
            chk("owner", 32'(owner), 32'(e.owner));
        end
    endtask

    logic [1:0] prev_g;
    logic [1:0] pat;

    initial begin
        // Reset with both requesting
        step(1'b0, 2'b11);
        step(1'b0, 2'b11);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        step(1'b1, 2'b11);
        chk("rst_first", 32'(gnt), 32'b01);

        // Single requester 1
        step(1'b0, 2'b00);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 2'b10);
            chk("single_gnt", 32'(gnt), 32'b10);
            chk("single_pre", 32'(preempt), 32'd0);
        end
        step(1'b1, 2'b00);
        chk("rel_turn", 32'({gnt, busy, preempt}), 32'b00_1_0);
        step(1'b1, 2'b00);
        chk("rel_idle", 32'(busy), 32'd0);

        // Contention: period 2*(MAXHOLD+1)
        step(1'b0, 2'b00);
        for (int k = 0; k < 25; k++) begin
            step(1'b1, 2'b11);
            case (k % 10)
                0, 1, 2, 3: pat = 2'b01;
                5, 6, 7, 8: pat = 2'b10;
                default:    pat = 2'b00;
            endcase
            chk("rr_gnt", 32'(gnt), 32'(pat));
            chk("rr_pre", 32'(preempt), 32'(pat == 2'b00));
        end

        // Voluntary release on the tenure-limit cycle
        step(1'b0, 2'b00);
        for (int k = 0; k < 4; k++) step(1'b1, 2'b11);
        chk("tie_cnt", 32'(dut.u_cnt.cnt), 32'd3);
        step(1'b1, 2'b10);
        chk("tie_turn", 32'({gnt, preempt}), 32'b00_0);
        step(1'b1, 2'b10);
        chk("tie_next", 32'(gnt), 32'b10);

        // Reset in the middle of a G1 tenure
        step(1'b0, 2'b00);
        for (int k = 0; k < 8; k++) step(1'b1, 2'b11);
        chk("mid_g1", 32'(gnt), 32'b10);
        chk("mid_cnt", 32'(dut.u_cnt.cnt), 32'd2);
        step(1'b0, 2'b11);
        chk("mid_drop", 32'({gnt, busy, preempt}), 32'b00_0_0);
        step(1'b1, 2'b11);
        chk("mid_next", 32'(gnt), 32'b01);

        // Random soak with invariant checks
        step(1'b0, 2'b00);
        prev_g = 2'b00;
        for (int k = 0; k < 2000; k++) begin
            step(1'b1, 2'($urandom_range(0, 3)));
            chk("inv_excl", 32'(gnt != 2'b11), 32'd1);
            chk("inv_gap",
                32'(prev_g == 2'b00 || gnt == 2'b00 || gnt == prev_g),
                32'd1);
            chk("inv_cnt", 32'(dut.u_cnt.cnt <= 2'(MAXHOLD - 1)), 32'd1);
            prev_g = gnt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
